param_register_file: RTL

//   Parametrised multi-read-port register file for the pipelined MIPS datapath, with a hard-wired zero register.

---
 rtl/rf_pkg.sv | 12 +
 rtl/rf_scoreboard.sv | 34 +++
 rtl/param_register_file.sv | 109 ++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and defaults for the parametrised register file
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-write bits with set-wins priority
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                     clock,
  input  logic                     Reset,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  output logic [(1<<ADDR_W)-1:0]   pending
);

  localparam int DEPTH = 1 << ADDR_W;

  // A reservation from a newer instruction beats a writeback from an older one
  always_ff @(posedge clock) begin
    if (Reset) begin
      pending <= '0;
    end else begin
      pending[0] <= 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
        if (set_en && set_addr == ADDR_W'(i)) begin
          pending[i] <= 1'b1;
        end else if (clr_en && clr_addr == ADDR_W'(i)) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - multi-port register file with bypass, scoreboard and clear engine
module param_register_file
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                       clock,
  input  logic                       Reset,
  input  logic                       clear_req,
  input  logic                       read_sig,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_hazard,
  input  logic                       write_sig,
  input  logic [ADDR_W-1:0]          d_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic                       ready,
  input  logic [ADDR_W-1:0]          dbg_addr,
  output logic [DATA_W-1:0]          dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  rf_state_t         state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
  logic [DEPTH-1:0]  pending;
  logic              wr_accept;
  logic              rsv_accept;

  // Reset gates ready so that nothing is accepted in a reset cycle, whatever state we were in
  assign ready      = (state == RF_IDLE) && !Reset;
  assign wr_accept  = write_sig && ready && (d_addr != '0);
  assign rsv_accept = rsv_en && ready && (rsv_addr != '0);

  // Clear FSM state register
  always_ff @(posedge clock) begin
    state   <= state_nxt;
    clr_ptr <= clr_ptr_nxt;
  end

  // Clear FSM next state; reset always (re)starts a clear from register 1
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    if (Reset) begin
      state_nxt   = RF_CLEAR;
      clr_ptr_nxt = ADDR_W'(1);
    end else begin
      case (state)
        RF_IDLE: begin
          if (clear_req) begin
            state_nxt   = RF_CLEAR;
            clr_ptr_nxt = ADDR_W'(1);
          end
        end
        RF_CLEAR: begin
          clr_ptr_nxt = clr_ptr + ADDR_W'(1);
          if (clr_ptr == ADDR_W'(DEPTH - 1)) begin
            state_nxt = RF_IDLE;
          end
        end
        default: begin
          state_nxt = RF_CLEAR;
          clr_ptr_nxt = ADDR_W'(1);
        end
      endcase
    end
  end

  // Array update: the clear engine and writeback are mutually exclusive because writes need ready
  always_ff @(posedge clock) begin
    if (state == RF_CLEAR && !Reset) begin
      mem[clr_ptr] <= '0;
    end else if (wr_accept) begin
      mem[d_addr] <= wb_data;
    end
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clock    (clock),
    .Reset    (Reset),
    .set_en   (rsv_accept),
    .set_addr (rsv_addr),
    .clr_en   (wr_accept),
    .clr_addr (d_addr),
    .pending  (pending)
  );

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit;
    assign addr = rd_addr[g*ADDR_W +: ADDR_W];
    assign hit  = BYPASS && wr_accept && (d_addr == addr);
    assign rd_data[g*DATA_W +: DATA_W] = (!read_sig || addr == '0) ? '0 :
                                         hit ? wb_data : mem[addr];
    assign rd_hazard[g] = read_sig && !Reset && pending[addr] && !hit;
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule
